// File: rtl/pid_mixer_if.sv
// pid_mixer_if: inertial-reading inputs and mixed motor-speed outputs of pid_mixer.
// The controller side (slave) consumes attitude/thrust and drives the speeds.
interface pid_mixer_if #(
  parameter int SPD_W = 11
);
  logic               vld;
  logic               inertial_cal;
  logic signed [15:0] d_ptch, d_roll, d_yaw;
  logic signed [15:0] ptch, roll, yaw;
  logic        [8:0]  thrst;
  logic [SPD_W-1:0]   frnt_spd, bck_spd, lft_spd, rght_spd;
  logic               spd_vld;
  logic               busy;

  modport master (
    output vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, busy
  );

  modport slave (
    input  vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
    output frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, busy
  );
endinterface

// File: rtl/pid_mixer.sv
// pid_mixer: time-multiplexed PID over pitch/roll/yaw feeding a quad motor mixer.
// One shared error/P/D datapath is stepped over the three axes (PTCH, ROLL, YAW),
// then MIX loads four clamped, registered motor speeds and pulses spd_vld.
// Optional integral term: define PID_I_TERM_EN to add per-axis integrators.
module pid_mixer #(
  parameter int               D_QUEUE_DEPTH = 14,
  parameter int               D_COEFF       = 7,
  parameter int               ERR_W         = 10,
  parameter int               SPD_W         = 11,
  parameter logic [SPD_W-1:0] CAL_SPEED     = 11'h1B0,
  parameter int               MIN_RUN_SPEED = 512,
  parameter int               I_SHIFT       = 6
)(
  input  logic       clk,
  input  logic       rst_n,
  pid_mixer_if.slave bus
);
  localparam int MIX_W  = SPD_W + 2;
  localparam int TERM_W = MIX_W;
  localparam int DIF_W  = ERR_W + 1;

  localparam logic signed [16:0]       EMAX = 17'(2**(ERR_W-1) - 1);
  localparam logic signed [16:0]       EMIN = -EMAX - 17'sd1;
  localparam logic signed [DIF_W-1:0]  DMAX = DIF_W'(31);
  localparam logic signed [DIF_W-1:0]  DMIN = DIF_W'(-32);
  localparam logic signed [TERM_W-1:0] DCO  = TERM_W'(D_COEFF);
  localparam logic signed [MIX_W-1:0]  SMAX = MIX_W'(2**SPD_W - 1);
  localparam logic signed [MIX_W-1:0]  BASE = MIX_W'(MIN_RUN_SPEED);

  typedef enum logic [2:0] {IDLE, PTCH, ROLL, YAW, MIX} state_t;
  state_t state, state_nxt;

  // snapshot of the reading being processed, index 0/1/2 = pitch/roll/yaw
  logic [2:0][15:0] des_q, act_q;
  logic [8:0]       thrst_q;

  logic [1:0]       ax;
  logic             axis_act;
  logic [2:0]       shift;

  logic signed [16:0]       err_raw;
  logic signed [ERR_W-1:0]  err_sat;
  logic signed [ERR_W-1:0]  tail_sel;
  logic signed [DIF_W-1:0]  diff;
  logic signed [5:0]        diff_sat;
  logic signed [TERM_W-1:0] pterm, dterm, pd;

  logic [2:0][ERR_W-1:0]  tails;
  logic [2:0][TERM_W-1:0] terms;

  logic signed [MIX_W-1:0] base, p_t, r_t, y_t;
  logic signed [MIX_W-1:0] frnt_s, bck_s, lft_s, rght_s;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: a reading is only accepted while idle, extra vld is dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.vld) state_nxt = PTCH;
      PTCH:    state_nxt = ROLL;
      ROLL:    state_nxt = YAW;
      YAW:     state_nxt = MIX;
      MIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // capture attitude and thrust when a reading is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      des_q   <= '0;
      act_q   <= '0;
      thrst_q <= '0;
    end else if (state == IDLE && bus.vld) begin
      des_q   <= {bus.d_yaw, bus.d_roll, bus.d_ptch};
      act_q   <= {bus.yaw, bus.roll, bus.ptch};
      thrst_q <= bus.thrst;
    end
  end

  // which axis owns the shared datapath this cycle
  always_comb begin
    ax       = 2'd0;
    axis_act = 1'b0;
    case (state)
      PTCH: begin ax = 2'd0; axis_act = 1'b1; end
      ROLL: begin ax = 2'd1; axis_act = 1'b1; end
      YAW:  begin ax = 2'd2; axis_act = 1'b1; end
      default: ;
    endcase
  end

  // shared error -> P + D datapath for the selected axis
  always_comb begin
    err_raw = 17'(signed'(act_q[ax])) - 17'(signed'(des_q[ax]));
    if (err_raw > EMAX)      err_sat = EMAX[ERR_W-1:0];
    else if (err_raw < EMIN) err_sat = EMIN[ERR_W-1:0];
    else                     err_sat = err_raw[ERR_W-1:0];

    pterm = TERM_W'(err_sat >>> 1) + TERM_W'(err_sat >>> 3);

    tail_sel = tails[ax];
    diff     = DIF_W'(err_sat) - DIF_W'(tail_sel);
    if (diff > DMAX)      diff_sat = DMAX[5:0];
    else if (diff < DMIN) diff_sat = DMIN[5:0];
    else                  diff_sat = diff[5:0];

    dterm = TERM_W'(diff_sat) * DCO;
    pd    = pterm + dterm;
  end

  // per-axis history queue, integrator and term register
  for (genvar a = 0; a < 3; a++) begin : g_axis
    assign shift[a] = axis_act && (ax == 2'(a));

    pid_mixer_axis #(
      .DEPTH   (D_QUEUE_DEPTH),
      .ERR_W   (ERR_W),
      .TERM_W  (TERM_W),
      .I_SHIFT (I_SHIFT)
    ) u_axis (
      .clk   (clk),
      .rst_n (rst_n),
      .shift (shift[a]),
      .cal   (bus.inertial_cal),
      .err   (err_sat),
      .pd    (pd),
      .tail  (tails[a]),
      .term  (terms[a])
    );
  end

  function automatic logic [SPD_W-1:0] clamp(input logic signed [MIX_W-1:0] s);
    if (s < 0)         return '0;
    else if (s > SMAX) return '1;
    else               return s[SPD_W-1:0];
  endfunction

  // motor mix from the registered axis terms
  always_comb begin
    base   = BASE + signed'(MIX_W'(thrst_q));
    p_t    = signed'(terms[0]);
    r_t    = signed'(terms[1]);
    y_t    = signed'(terms[2]);
    frnt_s = base - p_t - y_t;
    bck_s  = base + p_t - y_t;
    lft_s  = base - r_t + y_t;
    rght_s = base + r_t + y_t;
  end

  // output registers: calibration overrides everything, otherwise load on MIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.frnt_spd <= '0;
      bus.bck_spd  <= '0;
      bus.lft_spd  <= '0;
      bus.rght_spd <= '0;
      bus.spd_vld  <= 1'b0;
    end else begin
      bus.spd_vld <= (state == MIX);
      if (bus.inertial_cal) begin
        bus.frnt_spd <= CAL_SPEED;
        bus.bck_spd  <= CAL_SPEED;
        bus.lft_spd  <= CAL_SPEED;
        bus.rght_spd <= CAL_SPEED;
      end else if (state == MIX) begin
        bus.frnt_spd <= clamp(frnt_s);
        bus.bck_spd  <= clamp(bck_s);
        bus.lft_spd  <= clamp(lft_s);
        bus.rght_spd <= clamp(rght_s);
      end
    end
  end

  assign bus.busy = (state != IDLE);
endmodule

// pid_mixer_axis: one axis lane -- D-term error history, optional integrator,
// and the registered axis term. Everything updates only in the lane's own cycle.
module pid_mixer_axis #(
  parameter int DEPTH   = 14,
  parameter int ERR_W   = 10,
  parameter int TERM_W  = 13,
  parameter int I_SHIFT = 6
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift,
  input  logic                     cal,
  input  logic signed [ERR_W-1:0]  err,
  input  logic signed [TERM_W-1:0] pd,
  output logic        [ERR_W-1:0]  tail,
  output logic signed [TERM_W-1:0] term
);
  logic [DEPTH-1:0][ERR_W-1:0] q, q_nxt;
  logic signed [TERM_W-1:0]    term_nxt;

  if (DEPTH == 1) begin : g_q1
    assign q_nxt = err;
  end else begin : g_qn
    assign q_nxt = {q[DEPTH-2:0], err};
  end

  assign tail = q[DEPTH-1];

  // error history: newest at [0], oldest at the tail used by the D term
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (shift) q <= q_nxt;
  end

`ifdef PID_I_TERM_EN
  localparam logic signed [15:0] IMAX = 16'(2**(ERR_W-1) - 1);
  localparam logic signed [15:0] IMIN = -IMAX - 16'sd1;

  logic signed [15:0]      integ, integ_nxt, ishr;
  logic signed [16:0]      isum;
  logic signed [ERR_W-1:0] iterm;

  // saturating accumulate; iterm follows the freshly accumulated value
  always_comb begin
    isum = 17'(integ) + 17'(err);
    if (isum > 17'sd32767)       integ_nxt = 16'sh7FFF;
    else if (isum < -17'sd32768) integ_nxt = 16'sh8000;
    else                         integ_nxt = isum[15:0];
    ishr = integ_nxt >>> I_SHIFT;
    if (ishr > IMAX)      iterm = IMAX[ERR_W-1:0];
    else if (ishr < IMIN) iterm = IMIN[ERR_W-1:0];
    else                  iterm = ishr[ERR_W-1:0];
    term_nxt = pd + TERM_W'(iterm);
  end

  // integrator: wiped while the IMU calibrates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     integ <= '0;
    else if (cal)   integ <= '0;
    else if (shift) integ <= integ_nxt;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cal, 32'(I_SHIFT)};
  assign term_nxt   = pd;
`endif

  // registered axis term consumed by the mixer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     term <= '0;
    else if (shift) term <= term_nxt;
  end
endmodule

// File: tb/tb_pid_mixer.sv
// tb_pid_mixer: directed checks of pid_mixer with hand-computed speeds.
module tb_pid_mixer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pid_mixer_if #(.SPD_W(11)) bus();

  pid_mixer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int lat, busy_cnt, pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int dp, input int p, input int r, input int y, input int t);
    bus.d_ptch = 16'(dp);
    bus.d_roll = '0;
    bus.d_yaw  = '0;
    bus.ptch   = 16'(p);
    bus.roll   = 16'(r);
    bus.yaw    = 16'(y);
    bus.thrst  = 9'(t);
  endtask

  // one-cycle vld, then wait (bounded) for spd_vld; records latency and busy cycles
  task automatic run_sample();
    bus.vld = 1'b1;
    tick();
    bus.vld = 1'b0;
    busy_cnt = int'(bus.busy);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (bus.busy)    busy_cnt++;
      if (bus.spd_vld) lat = i;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.vld = 1'b0;
    bus.inertial_cal = 1'b0;
    set_in(0, 0, 0, 0, 0);
    tick();
    tick();

    // reset state
    chk("rst_frnt", bus.frnt_spd, 0);
    chk("rst_rght", bus.rght_spd, 0);
    chk("rst_vld",  bus.spd_vld, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();

    // all-zero reading: latency 4, busy 4 cycles, base 512 everywhere
    run_sample();
    chk("zero_lat",  lat, 4);
    chk("zero_busy", busy_cnt, 4);
    chk("zero_frnt", bus.frnt_spd, 512);
    chk("zero_bck",  bus.bck_spd, 512);
    chk("zero_lft",  bus.lft_spd, 512);
    chk("zero_rght", bus.rght_spd, 512);

    // pitch 100: P = 62 + 217 = 279
    set_in(0, 100, 0, 0, 0);
    run_sample();
    chk("p100_frnt", bus.frnt_spd, 233);
    chk("p100_bck",  bus.bck_spd, 791);
    chk("p100_lft",  bus.lft_spd, 512);
    chk("p100_rght", bus.rght_spd, 512);
    for (int s = 2; s <= 14; s++) begin
      run_sample();
      chk($sformatf("p100_hold%0d", s), bus.frnt_spd, 233);
    end
    // 15th sample sees its own first entry at the tail: diff 0, P = 62
    run_sample();
    chk("p100_s15_frnt", bus.frnt_spd, 450);
    chk("p100_s15_bck",  bus.bck_spd, 574);

    // large negative errors, full thrust: upper clamp
    do_reset();
    set_in(0, -5000, 0, -5000, 511);
    run_sample();
    chk("neg_frnt", bus.frnt_spd, 2047);
    chk("neg_bck",  bus.bck_spd, 1023);
    chk("neg_lft",  bus.lft_spd, 479);
    chk("neg_rght", bus.rght_spd, 479);
    // lower clamp
    set_in(0, -5000, 0, 0, 0);
    run_sample();
    chk("low_bck",  bus.bck_spd, 0);
    chk("low_frnt", bus.frnt_spd, 1056);
    chk("low_lft",  bus.lft_spd, 512);

    // vld held through PTCH/ROLL is ignored: exactly one result
    set_in(0, 0, 0, 0, 0);
    bus.vld = 1'b1;
    tick();
    tick();
    tick();
    bus.vld = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.spd_vld) pulses++;
    end
    chk("busy_vld_pulses", pulses, 1);
    chk("busy_vld_frnt", bus.frnt_spd, 512);

    // calibration forces CAL_SPEED and holds it until the next MIX
    bus.inertial_cal = 1'b1;
    tick();
    chk("cal_frnt", bus.frnt_spd, 432);
    chk("cal_lft",  bus.lft_spd, 432);
    bus.inertial_cal = 1'b0;
    tick();
    tick();
    chk("cal_hold_bck",  bus.bck_spd, 432);
    chk("cal_hold_rght", bus.rght_spd, 432);
    run_sample();
    chk("cal_after_mix", bus.frnt_spd, 512);

    // reset during ROLL abandons the sequence
    set_in(0, 100, 0, 0, 0);
    bus.vld = 1'b1;
    tick();
    bus.vld = 1'b0;
    tick();
    chk("roll_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_frnt", bus.frnt_spd, 0);
    chk("midrst_busy", bus.busy, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) rst_n = 1'b1;
      tick();
      if (bus.spd_vld) pulses++;
    end
    chk("midrst_pulses", pulses, 0);
    run_sample();
    chk("postrst_lat",  lat, 4);
    chk("postrst_frnt", bus.frnt_spd, 233);
    chk("postrst_bck",  bus.bck_spd, 791);

    // desired ahead of actual: err -100, P = -63 - 224 = -287
    set_in(100, 0, 0, 0, 0);
    run_sample();
    chk("dp_frnt", bus.frnt_spd, 799);
    chk("dp_bck",  bus.bck_spd, 225);

    // roll axis: R = 279
    set_in(0, 0, 100, 0, 0);
    run_sample();
    chk("roll_lft",  bus.lft_spd, 233);
    chk("roll_rght", bus.rght_spd, 791);
    chk("roll_frnt", bus.frnt_spd, 512);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
